pkt_slot_buffer: RTL and testbench
==================================

// Module: pkt_slot_buffer
// PURPOSE
//  Parametrised multi-slot successor of the single-packet convertible FIFO in the pipelined packet datapath.
//  Packets arrive on the NetFPGA in_* stream and land in NUM_SLOTS ring slots. The CPU port then owns one
//  READY slot at a time: random read/write plus first/last word index. On cpu_done the slot drains in order
//  on the out_* stream, while later slots keep filling.
// PARAMETERS
//  DATA_WIDTH  64             stream/memory word width
//  CTRL_WIDTH  DATA_WIDTH/8   NetFPGA ctrl width
//  NUM_SLOTS   4              packet slots; power of 2, >=2
//  SLOT_AW     8              log2 words per slot (slot depth 2**SLOT_AW)
// PORTS
//  clk        in   1           single clock
//  reset      in   1           synchronous, active-high
//  in_data    in   DATA_WIDTH  input word
//  in_ctrl    in   CTRL_WIDTH  input ctrl; nonzero = header/EOP word
//  in_wr      in   1           input word valid
//  in_rdy     out  1           buffer can take a word this cycle
//  out_data   out  DATA_WIDTH  drained word (registered)
//  out_ctrl   out  CTRL_WIDTH  drained ctrl (registered)
//  out_wr     out  1           out word valid
//  out_rdy    in   1           downstream accepts; one word of slack after fall
//  cpu_valid  out  1           CPU slot is READY
//  cpu_addr   in   SLOT_AW     word index inside CPU slot
//  cpu_wr     in   1           write cpu_wdata at cpu_addr (data field only; ctrl kept)
//  cpu_wdata  in   DATA_WIDTH  CPU write data
//  cpu_rdata  out  DATA_WIDTH  data at cpu_addr, 1-cycle latency
//  cpu_first  out  SLOT_AW     index of first word of packet (always 0)
//  cpu_last   out  SLOT_AW     index of EOP word
//  cpu_done   in   1           pulse: release CPU slot to drain; ignored if !cpu_valid
//  full       out  1           all slots non-FREE
// BEHAVIOUR
//  Per-slot state: FREE -> FILL -> READY -> DRAIN -> FREE. Three pointers, each mod NUM_SLOTS:
//  - wr_ptr: slot being filled
//  - cpu_ptr: slot CPU owns
//  - rd_ptr: slot draining
//  Each pointer advances only on leaving its state, so order is kept.
//  Reset (any cycle, incl. mid-packet or mid-drain): all slots FREE, pointers 0, word counters 0.
//   Outputs after reset: in_rdy=1, out_wr=0, out_data/out_ctrl=0, cpu_valid=0, cpu_rdata=0,
//   cpu_last=0, full=0.
//  Fill:
//  - in_rdy = (slot[wr_ptr] is FREE or FILL) && !cpu_wr. CPU write has priority on the single write port.
//  - A word is accepted when in_wr && in_rdy and is stored at wr_ptr:wcnt; wcnt then increments.
//  - EOP = accepted word with in_ctrl!=0 after at least one in_ctrl==0 word.
//    At EOP: slot -> READY, last index = wcnt, wr_ptr++, wcnt = 0.
//  - Oversize (word accepted with wcnt == 2**SLOT_AW-1 and not EOP): drop the rest of the packet up to EOP.
//    The slot returns to FREE at that EOP and wr_ptr does not advance.
//  - in_wr while !in_rdy is a protocol error; the word is dropped.
//  CPU:
//  - cpu_valid = slot[cpu_ptr]==READY. cpu_last holds that slot's EOP index.
//  - Reads are synchronous: cpu_rdata is valid 1 cycle after cpu_addr.
//  - cpu_wr with !cpu_valid is ignored.
//  - cpu_done: slot -> DRAIN, cpu_ptr++. cpu_valid is low the next cycle and rises again only if the new
//    slot is READY.
//  Drain:
//  - FSM D_IDLE/D_RUN.
//  - D_IDLE -> D_RUN when slot[rd_ptr]==DRAIN.
//  - In D_RUN, each cycle with out_rdy=1 issues a read of word rcnt. The next cycle gives out_wr=1 with
//    that word. Throughput 1 word/cycle.
//  - After issuing rcnt == last: slot -> FREE, rd_ptr++, back to D_IDLE. Back-to-back DRAIN slots add
//    one idle cycle.
//  Simultaneous events:
//  - Fill-EOP, cpu_done and drain-finish on different slots in the same cycle all take effect.
//  - full = no FREE slot.
// CONFIGURATION
//  PKT_SLOT_BUFFER_STATS_EN defined: adds outputs
//   - pkt_in_cnt[31:0] (EOPs accepted)
//   - pkt_drop_cnt[31:0] (oversize drops)
//   - pkt_out_cnt[31:0] (slots drained)
//   Counters wrap at 2**32 and are cleared by reset.
//  Undefined: these ports and counters are absent; drop behaviour is unchanged.
// STRUCTURE
//  Package pkt_buf_pkg holds:
//   - slot-state encoding SLOT_FREE/FILL/READY/DRAIN (2 bits)
//   - drain FSM state encoding
//   - the EOP-detect rule as a function
//  Sub-module pkt_buf_ram:
//   - NUM_SLOTS*2**SLOT_AW x (DATA_WIDTH+CTRL_WIDTH)
//   - one write port, two synchronous read ports (CPU, drain)
//   - memory contents are not reset
// TESTING
//  1. 4-word packet (ctrl FF,00,00,80) -> cpu_valid after EOP, cpu_last=3. Read idx2 returns word2.
//     cpu_done -> 4 out_wr beats, identical data/ctrl.
//  2. CPU writes 0xDEAD at idx1 then cpu_done -> drained word1 data=0xDEAD with its original ctrl.
//  3. 5 packets with no cpu_done (NUM_SLOTS=4) -> full=1 and in_rdy=0 after 4th EOP. 5th packet stalls;
//     it is accepted after one cpu_done and full drain.
//  4. 300-word packet (SLOT_AW=8) -> no cpu_valid, slot reused by the next packet. pkt_drop_cnt=1 with
//     STATS_EN.
//  5. out_rdy toggled 1,0,1,0 during drain -> no word lost or duplicated; 1-word slack honoured.
//  6. reset asserted mid-fill and mid-drain -> next cycle every output is at its reset value; a fresh
//     packet lands in slot 0.

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared types for the packet slot buffer: slot life-cycle states, drain FSM states and
// the end-of-packet rule used by the fill side.
package pkt_buf_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_FILL  = 2'd1,
        SLOT_READY = 2'd2,
        SLOT_DRAIN = 2'd3
    } slot_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_RUN  = 1'b1
    } drain_state_e;

    // Leading nonzero-ctrl words are module headers; only a nonzero ctrl after payload ends it.
    function automatic logic eop_detect(input logic ctrl_nz, input logic seen_payload);
        return ctrl_nz && seen_payload;
    endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Word store for all slots: one write port with separate ctrl enable, two registered read
// ports (CPU data, drain data+ctrl). Array contents are not reset, only the read registers.
module pkt_buf_ram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  we_ctrl,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [CTRL_WIDTH-1:0] wctrl,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_re,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [CTRL_WIDTH-1:0] b_rctrl
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];

    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic [CTRL_WIDTH-1:0] b_rctrl_q, b_rctrl_d;

    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[waddr] <= wdata;
        end
        if (we && we_ctrl) begin
            ctrl_mem[waddr] <= wctrl;
        end
    end

    // Drain port holds its last word when idle so out_data stays stable between beats.
    always_comb begin
        a_rdata_d = data_mem[a_addr];
        b_rdata_d = b_rdata_q;
        b_rctrl_d = b_rctrl_q;
        if (b_re) begin
            b_rdata_d = data_mem[b_addr];
            b_rctrl_d = ctrl_mem[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            b_rctrl_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            b_rctrl_q <= b_rctrl_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign b_rctrl = b_rctrl_q;

endmodule

// File: rtl/pkt_slot_buffer.sv
// Ring of packet slots: stream fill, CPU random access on one READY slot, in-order drain.
// Define PKT_SLOT_BUFFER_STATS_EN to add the pkt_in/drop/out counters.
module pkt_slot_buffer
    import pkt_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_AW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  cpu_valid,
    input  logic [SLOT_AW-1:0]    cpu_addr,
    input  logic                  cpu_wr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [SLOT_AW-1:0]    cpu_first,
    output logic [SLOT_AW-1:0]    cpu_last,
    input  logic                  cpu_done,
    output logic                  full
`ifdef PKT_SLOT_BUFFER_STATS_EN
    ,
    output logic [31:0]           pkt_in_cnt,
    output logic [31:0]           pkt_drop_cnt,
    output logic [31:0]           pkt_out_cnt
`endif
);

    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned AW = SW + SLOT_AW;
    localparam logic [SLOT_AW-1:0] WMAX = '1;

    slot_state_e        slot_q [NUM_SLOTS];
    slot_state_e        slot_d [NUM_SLOTS];
    logic [SLOT_AW-1:0] last_q [NUM_SLOTS];
    logic [SLOT_AW-1:0] last_d [NUM_SLOTS];
    logic [SW-1:0]      wr_ptr_q, wr_ptr_d, cpu_ptr_q, cpu_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SLOT_AW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic               seen_q, seen_d, drop_q, drop_d, blank_q, blank_d, out_wr_q, out_wr_d;
    drain_state_e       dstate_q, dstate_d;

    logic                  in_acc, eop;
    logic                  ram_we, ram_we_ctrl, ram_b_re;
    logic [AW-1:0]         ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign in_rdy    = ((slot_q[wr_ptr_q] == SLOT_FREE) || (slot_q[wr_ptr_q] == SLOT_FILL))
                       && !cpu_wr;
    assign in_acc    = in_wr && in_rdy;
    assign eop       = eop_detect(|in_ctrl, seen_q);
    // One dead cycle after cpu_done so software sees the hand-over even if the next slot is READY.
    assign cpu_valid = (slot_q[cpu_ptr_q] == SLOT_READY) && !blank_q;
    assign cpu_first = '0;
    assign cpu_last  = last_q[cpu_ptr_q];
    assign out_wr    = out_wr_q;

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q[i] == SLOT_FREE) full = 1'b0;
        end
    end

    always_comb begin
        slot_d      = slot_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        cpu_ptr_d   = cpu_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        seen_d      = seen_q;
        drop_d      = drop_q;
        blank_d     = 1'b0;
        out_wr_d    = 1'b0;
        dstate_d    = dstate_q;
        ram_we      = 1'b0;
        ram_we_ctrl = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = '0;
        ram_b_re    = 1'b0;

        if (in_acc) begin
            if (drop_q) begin
                if (eop) begin
                    slot_d[wr_ptr_q] = SLOT_FREE;
                    wcnt_d = '0;
                    seen_d = 1'b0;
                    drop_d = 1'b0;
                end else if (in_ctrl == '0) begin
                    seen_d = 1'b1;
                end
            end else begin
                ram_we      = 1'b1;
                ram_we_ctrl = 1'b1;
                ram_waddr   = {wr_ptr_q, wcnt_q};
                ram_wdata   = in_data;
                if (eop) begin
                    slot_d[wr_ptr_q] = SLOT_READY;
                    last_d[wr_ptr_q] = wcnt_q;
                    wr_ptr_d = SW'(wr_ptr_q + 1'b1);
                    wcnt_d   = '0;
                    seen_d   = 1'b0;
                end else begin
                    slot_d[wr_ptr_q] = SLOT_FILL;
                    if (in_ctrl == '0) seen_d = 1'b1;
                    if (wcnt_q == WMAX) drop_d = 1'b1;
                    else                wcnt_d = wcnt_q + 1'b1;
                end
            end
        end

        // in_rdy is low whenever cpu_wr is high, so the write port is never contended.
        if (cpu_wr && cpu_valid) begin
            ram_we    = 1'b1;
            ram_waddr = {cpu_ptr_q, cpu_addr};
            ram_wdata = cpu_wdata;
        end

        if (cpu_done && cpu_valid) begin
            slot_d[cpu_ptr_q] = SLOT_DRAIN;
            cpu_ptr_d = SW'(cpu_ptr_q + 1'b1);
            blank_d   = 1'b1;
        end

        unique case (dstate_q)
            D_IDLE: begin
                if (slot_q[rd_ptr_q] == SLOT_DRAIN) begin
                    dstate_d = D_RUN;
                    rcnt_d   = '0;
                end
            end
            D_RUN: begin
                if (out_rdy) begin
                    ram_b_re = 1'b1;
                    out_wr_d = 1'b1;
                    if (rcnt_q == last_q[rd_ptr_q]) begin
                        slot_d[rd_ptr_q] = SLOT_FREE;
                        rd_ptr_d = SW'(rd_ptr_q + 1'b1);
                        dstate_d = D_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= SLOT_FREE;
                last_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            cpu_ptr_q <= '0;
            rd_ptr_q  <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            seen_q    <= 1'b0;
            drop_q    <= 1'b0;
            blank_q   <= 1'b0;
            out_wr_q  <= 1'b0;
            dstate_q  <= D_IDLE;
        end else begin
            slot_q    <= slot_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            cpu_ptr_q <= cpu_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            seen_q    <= seen_d;
            drop_q    <= drop_d;
            blank_q   <= blank_d;
            out_wr_q  <= out_wr_d;
            dstate_q  <= dstate_d;
        end
    end

    pkt_buf_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .CTRL_WIDTH(CTRL_WIDTH),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (ram_we),
        .we_ctrl(ram_we_ctrl),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .wctrl  (in_ctrl),
        .a_addr ({cpu_ptr_q, cpu_addr}),
        .a_rdata(cpu_rdata),
        .b_re   (ram_b_re),
        .b_addr ({rd_ptr_q, rcnt_q}),
        .b_rdata(out_data),
        .b_rctrl(out_ctrl)
    );

`ifdef PKT_SLOT_BUFFER_STATS_EN
    logic [31:0] in_cnt_q, in_cnt_d, drop_cnt_q, drop_cnt_d, out_cnt_q, out_cnt_d;

    always_comb begin
        in_cnt_d   = in_cnt_q;
        drop_cnt_d = drop_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (in_acc && !drop_q && eop) in_cnt_d = in_cnt_q + 32'd1;
        if (in_acc && !drop_q && !eop && (wcnt_q == WMAX)) drop_cnt_d = drop_cnt_q + 32'd1;
        if ((dstate_q == D_RUN) && out_rdy && (rcnt_q == last_q[rd_ptr_q])) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q   <= '0;
            drop_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign pkt_in_cnt   = in_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
    assign pkt_out_cnt  = out_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_slot_buffer.sv
// Randomised bench for pkt_slot_buffer against a packet-queue model of fill, CPU edit and drain.
module tb_pkt_slot_buffer;

    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int NS    = 4;
    localparam int SA    = 8;
    localparam int LIMIT = 3000;

    typedef logic [CW+DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr, in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr, out_rdy;
    logic          cpu_valid, cpu_wr, cpu_done;
    logic [SA-1:0] cpu_addr, cpu_first, cpu_last;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          full;
`ifdef PKT_SLOT_BUFFER_STATS_EN
    logic [31:0]   pkt_in_cnt, pkt_drop_cnt, pkt_out_cnt;
    int            exp_in, exp_drop, exp_out;
`endif

    always #5 clk = ~clk;

    pkt_slot_buffer #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .NUM_SLOTS (NS),
        .SLOT_AW   (SA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .cpu_valid(cpu_valid),
        .cpu_addr (cpu_addr),
        .cpu_wr   (cpu_wr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_first(cpu_first),
        .cpu_last (cpu_last),
        .cpu_done (cpu_done),
        .full     (full)
`ifdef PKT_SLOT_BUFFER_STATS_EN
        ,
        .pkt_in_cnt  (pkt_in_cnt),
        .pkt_drop_cnt(pkt_drop_cnt),
        .pkt_out_cnt (pkt_out_cnt)
`endif
    );

    // Model: packets held by CPU side (flat words + lengths) and words owed on the output.
    word_t rdy_words[$];
    int    rdy_len[$];
    word_t drain_q[$];
    int    drain_len[$];
    int    held;
    int    out_pos;
    int    rdy_mode;
    int    n_checks;
    int    n_errors;
    logic  rdy_last;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = ~out_rdy;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && out_wr) begin
            check_eq("out_slack", rdy_last, 1'b1);
            if (drain_q.size() == 0) begin
                check_eq("out_spurious", out_wr, 1'b0);
            end else begin
                check_eq("out_word", {out_ctrl, out_data}, drain_q.pop_front());
                out_pos++;
                if (out_pos == drain_len[0]) begin
                    void'(drain_len.pop_front());
                    out_pos = 0;
                    held--;
`ifdef PKT_SLOT_BUFFER_STATS_EN
                    exp_out++;
`endif
                end
            end
        end
        rdy_last = out_rdy;
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        check_eq("rst_in_rdy", in_rdy, 1'b1);
        check_eq("rst_out_wr", out_wr, 1'b0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_out_ctrl", out_ctrl, '0);
        check_eq("rst_cpu_valid", cpu_valid, 1'b0);
        check_eq("rst_cpu_rdata", cpu_rdata, '0);
        check_eq("rst_cpu_last", cpu_last, '0);
        check_eq("rst_full", full, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_wr    = 1'b0;
        cpu_wr   = 1'b0;
        cpu_done = 1'b0;
        rdy_words.delete();
        rdy_len.delete();
        drain_q.delete();
        drain_len.delete();
        held    = 0;
        out_pos = 0;
`ifdef PKT_SLOT_BUFFER_STATS_EN
        exp_in   = 0;
        exp_drop = 0;
        exp_out  = 0;
`endif
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs();
    endtask

    task automatic send_pkt(input int len, input logic [CW-1:0] eop_ctrl, input bit oversize);
        word_t w[$];
        bit    room = (held < NS);
        int    n;
        for (int i = 0; i < len; i++) begin
            logic [CW-1:0] c = (i == 0) ? 8'hFF : ((i == len - 1) ? eop_ctrl : 8'h00);
            w.push_back({c, $urandom, $urandom});
        end
        for (int i = 0; i < len; i++) begin
            in_wr   = 1'b1;
            in_ctrl = w[i][CW+DW-1:DW];
            in_data = w[i][DW-1:0];
            n = 0;
            @(negedge clk);
            if (i == 0 && room) check_eq("in_rdy_room", in_rdy, 1'b1);
            while (!in_rdy && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            if (!in_rdy) begin
                check_eq("in_rdy_timeout", in_rdy, 1'b1);
                in_wr = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_wr = 1'b0;
        if (oversize) begin
`ifdef PKT_SLOT_BUFFER_STATS_EN
            exp_drop++;
`endif
        end else begin
            foreach (w[i]) rdy_words.push_back(w[i]);
            rdy_len.push_back(len);
            held++;
`ifdef PKT_SLOT_BUFFER_STATS_EN
            exp_in++;
`endif
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!cpu_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check_eq("cpu_valid", cpu_valid, 1'b1);
        if (rdy_len.size() > 0) check_eq("cpu_last", cpu_last, SA'(rdy_len[0] - 1));
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input int idx);
        cpu_addr = SA'(idx);
        @(posedge clk);
        @(negedge clk);
        check_eq("cpu_rdata", cpu_rdata, rdy_words[idx][DW-1:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int idx, input logic [DW-1:0] d);
        word_t t = rdy_words[idx];
        cpu_addr  = SA'(idx);
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
        t[DW-1:0] = d;
        rdy_words[idx] = t;
    endtask

    task automatic cpu_release();
        int len = rdy_len.pop_front();
        cpu_done = 1'b1;
        for (int i = 0; i < len; i++) drain_q.push_back(rdy_words.pop_front());
        drain_len.push_back(len);
        @(posedge clk);
        #1;
        cpu_done = 1'b0;
        @(negedge clk);
        check_eq("cpu_valid_blank", cpu_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_session(input int nrd, input int nwr);
        wait_valid();
        for (int i = 0; i < nwr; i++) cpu_write($urandom_range(0, rdy_len[0] - 1), {$urandom, $urandom});
        for (int i = 0; i < nrd; i++) cpu_read($urandom_range(0, rdy_len[0] - 1));
        cpu_release();
    endtask

    task automatic wait_drained();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (held != rdy_len.size() && n < 5 * LIMIT);
        #1;
        check_eq("drain_done", held, rdy_len.size());
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rdy_mode  = 0;
        rdy_last  = 1'b1;
        in_data   = '0;
        in_ctrl   = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        do_reset(3);
        check_eq("cpu_first", cpu_first, '0);

        // Basic packet: read back word 2 then drain unchanged.
        send_pkt(4, 8'h80, 0);
        wait_valid();
        cpu_read(2);
        cpu_release();
        wait_drained();

        // CPU data write keeps the stored ctrl.
        send_pkt(4, 8'h80, 0);
        wait_valid();
        cpu_write(1, 64'hDEAD);
        cpu_read(1);
        cpu_release();
        wait_drained();

        // Fill all slots, then a fifth packet waits for one slot to drain.
        for (int i = 0; i < NS; i++) send_pkt($urandom_range(3, 20), 8'h80, 0);
        @(negedge clk);
        check_eq("full_set", full, 1'b1);
        check_eq("in_rdy_full", in_rdy, 1'b0);
        @(posedge clk);
        #1;
        fork
            send_pkt(6, 8'h10, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                cpu_session(2, 1);
            end
        join
        while (rdy_len.size() > 0) cpu_session(1, 1);
        wait_drained();
        @(negedge clk);
        check_eq("full_clear", full, 1'b0);
        @(posedge clk);
        #1;

        // Oversize packet is dropped and its slot reused by the next packet.
        send_pkt(300, 8'h40, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("oversize_no_valid", cpu_valid, 1'b0);
        check_eq("oversize_not_full", full, 1'b0);
`ifdef PKT_SLOT_BUFFER_STATS_EN
        check_eq("drop_cnt", pkt_drop_cnt, 32'(exp_drop));
`endif
        @(posedge clk);
        #1;
        send_pkt(5, 8'h01, 0);
        cpu_session(2, 0);
        wait_drained();

        // Alternating backpressure during drain.
        rdy_mode = 2;
        send_pkt(12, 8'h80, 0);
        cpu_session(1, 1);
        wait_drained();

        // Random mix of fills, edits and releases under random backpressure.
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            if (held < NS && (rdy_len.size() == 0 || $urandom_range(0, 1) == 1)) begin
                send_pkt($urandom_range(3, 40), CW'($urandom_range(1, 255)), 0);
            end else if (rdy_len.size() > 0) begin
                cpu_session($urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                wait_drained();
            end
        end
        while (rdy_len.size() > 0) cpu_session(1, 0);
        wait_drained();
`ifdef PKT_SLOT_BUFFER_STATS_EN
        check_eq("in_cnt", pkt_in_cnt, 32'(exp_in));
        check_eq("out_cnt", pkt_out_cnt, 32'(exp_out));
        check_eq("drop_cnt_end", pkt_drop_cnt, 32'(exp_drop));
`endif

        // Reset while one slot drains and the next is half filled.
        send_pkt(40, 8'h80, 0);
        cpu_session(0, 0);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_wr && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            check_eq("drain_started", out_wr, 1'b1);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            in_wr   = 1'b1;
            in_ctrl = (i == 0) ? 8'hFF : 8'h00;
            in_data = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        do_reset(1);
        send_pkt(7, 8'h80, 0);
        cpu_session(2, 2);
        wait_drained();
        check_eq("drain_q_empty", drain_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
